// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam int unsigned INSN_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetches are word-granular; the low two target bits carry no address information.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Valid/ready (pc, ir) stream from fetch to decode.
interface fetch_ctrl_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] ir;

  modport master (output valid, pc, ir, input ready);
  modport slave  (input valid, pc, ir, output ready);
endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched (pc, ir) entries with single-cycle flush.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != (PW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Empty buffer presents zeros so decode never sees a stale or uninitialised slot.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues ROM reads under buffer credit, drops stale fetches on redirect.
// Optional FETCH_MISALIGN_EN: misaligned redirect targets halt fetch and raise fault/fault_pc.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  fetch_ctrl_if.master      dec,
  output logic              halted
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              fault,
  output logic [31:0]       fault_pc
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned CR_W  = CNT_W + 1;

  fetch_state_e     state;
  logic [31:0]      pc;
  logic             epoch;
  logic             inflight;
  logic             infl_epoch;
  logic [31:0]      infl_pc;

  logic             run, mis, go_halt, take_redir, flush;
  logic             pop_raw, issue, push;
  logic [CNT_W-1:0] count;
  logic [CR_W-1:0]  used, limit;
  fetch_entry_t     head, din;

  assign run = (state == RUN);

`ifdef FETCH_MISALIGN_EN
  assign mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Halt outranks redirect; a misaligned redirect is treated as a halt request.
  assign go_halt    = run && (halt || mis);
  assign take_redir = run && redirect_valid && !go_halt;
  assign flush      = go_halt || take_redir;

  // Credit: buffered + in-flight entries must fit once this cycle's pop retires.
  assign pop_raw = dec.valid && dec.ready;
  assign used    = CR_W'(count) + CR_W'(inflight);
  assign limit   = CR_W'(BUF_DEPTH) + CR_W'(pop_raw);
  assign issue   = run && !flush && (used < limit);

  assign imem_en   = issue;
  assign imem_addr = pc[ADDR_W+1:2];

  assign push = inflight && (infl_epoch == epoch) && !flush;
  assign din  = '{pc: infl_pc, ir: imem_rdata};

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_raw),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign dec.valid = (count != '0);
  assign dec.pc    = head.pc;
  assign dec.ir    = head.ir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      epoch      <= 1'b0;
      inflight   <= 1'b0;
      infl_epoch <= 1'b0;
      infl_pc    <= '0;
      halted     <= 1'b0;
    end else begin
      inflight   <= issue;
      infl_epoch <= epoch;
      infl_pc    <= pc;
      if (issue) pc <= pc + 32'(INSN_BYTES);
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (go_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (take_redir) begin
            pc    <= align_pc(redirect_pc);
            epoch <= ~epoch;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (run && mis && !halt) begin
      fault    <= 1'b1;
      fault_pc <= redirect_pc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a (pc, ir) scoreboard checked on every accepted beat.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic              halted;
`ifdef FETCH_MISALIGN_EN
  logic              fault;
  logic [31:0]       fault_pc;
`endif

  fetch_ctrl_if dec ();

  fetch_ctrl #(.RESET_PC(32'h0), .ADDR_W(ADDR_W), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec            (dec),
    .halted         (halted)
`ifdef FETCH_MISALIGN_EN
    ,
    .fault          (fault),
    .fault_pc       (fault_pc)
`endif
  );

  always #5 clk = ~clk;

  // ROM[i] = i, one-cycle synchronous read.
  always @(posedge clk) if (imem_en) imem_rdata <= {{(32-ADDR_W){1'b0}}, imem_addr};

  int errors = 0;
  int checks = 0;
  fetch_entry_t sbq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] p;
      p = start + 32'(4 * k);
      sbq.push_back('{pc: p, ir: {{(32-ADDR_W){1'b0}}, p[ADDR_W+1:2]}});
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Beats accepted by the DUT: a pop in a flush cycle (redirect/halt) is ignored.
  always @(negedge clk) begin
    if (!rst && dec.valid && dec.ready && !redirect_valid && !halt) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: got unexpected pc %h want none", dec.pc);
      end
      if (sbq.size() != 0) begin
        fetch_entry_t e;
        e = sbq.pop_front();
        check("sb_pc", dec.pc, e.pc);
        check("sb_ir", dec.ir, e.ir);
      end
    end
  end

  initial begin
    logic [31:0] hp, hi;
    int issues, bad;
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec.ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(dec.valid), 32'd0);
    check("rst_imem_en",   32'(imem_en),   32'd0);
    check("rst_halted",    32'(halted),    32'd0);
    check("rst_out_pc",    dec.pc,         32'd0);
    check("rst_out_ir",    dec.ir,         32'd0);
    push_stream(32'h0, 48);

    drive_edge(); rst = 1'b0;                      // BOOT cycle
    @(negedge clk);
    check("boot_no_fetch", 32'(imem_en),   32'd0);
    check("boot_valid",    32'(dec.valid), 32'd0);
    @(negedge clk);
    check("run_first_en",   32'(imem_en),  32'd1);
    check("run_first_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("lat_valid_lo",  32'(dec.valid), 32'd0);
    @(negedge clk);
    check("first_valid",   32'(dec.valid), 32'd1);
    check("first_pc",      dec.pc,         32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_gap", 32'(dec.valid), 32'd1);
    end

    // Redirect with two entries buffered and one read in flight; pop collides with it.
    drive_edge(); dec.ready = 1'b0;
    drive_edge(); dec.ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    sbq.delete(); push_stream(32'h100, 48);
    drive_edge(); redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_en",     32'(imem_en),   32'd1);
    check("redir_addr",   32'(imem_addr), 32'h40);
    check("redir_flush",  32'(dec.valid), 32'd0);
    @(negedge clk);
    check("redir_gap",    32'(dec.valid), 32'd0);
    @(negedge clk);
    check("redir_valid",  32'(dec.valid), 32'd1);
    check("redir_pc",     dec.pc,         32'h100);
    repeat (6) @(negedge clk);

    // Back-pressure: head holds, issue bounded by buffer depth.
    drive_edge(); dec.ready = 1'b0; issues = 0;
    @(negedge clk);
    hp = dec.pc; hi = dec.ir;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (imem_en) issues++;
      check("stall_valid", 32'(dec.valid), 32'd1);
      check("stall_pc",    dec.pc, hp);
      check("stall_ir",    dec.ir, hi);
    end
    check("stall_issues_le_depth", 32'(issues <= DEPTH), 32'd1);
    drive_edge(); dec.ready = 1'b1;
    repeat (10) @(negedge clk);

    // ROM address wrap past 2^(ADDR_W+2) bytes.
    drive_edge(); redirect_valid = 1'b1; redirect_pc = 32'h1FFFC;
    sbq.delete(); push_stream(32'h1FFFC, 48);
    drive_edge(); redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_addr_top", 32'(imem_addr), 32'h7FFF);
    @(negedge clk);
    check("wrap_addr_zero", 32'(imem_addr), 32'h0);
    check("wrap_en",        32'(imem_en),   32'd1);
    @(negedge clk);
    check("wrap_pc0", dec.pc, 32'h1FFFC);
    @(negedge clk);
    check("wrap_pc1", dec.pc, 32'h20000);
    check("wrap_ir1", dec.ir, 32'h0);
    repeat (4) @(negedge clk);

    // Halt and redirect together: halt wins, target never fetched.
    drive_edge(); halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    sbq.delete();
    @(negedge clk);
    check("halt_cycle_no_issue", 32'(imem_en), 32'd0);
    drive_edge(); halt = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    check("halted_set",  32'(halted),    32'd1);
    check("halt_flush",  32'(dec.valid), 32'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_en) bad++;
    end
    check("halt_no_fetch", 32'(bad), 32'd0);
    drive_edge(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    drive_edge(); redirect_valid = 1'b0;
    @(negedge clk);
    check("halt_sticky",    32'(halted),  32'd1);
    check("halt_sticky_en", 32'(imem_en), 32'd0);

    // Reset from HALT restarts the boot sequence.
    drive_edge(); rst = 1'b1;
    sbq.delete(); push_stream(32'h0, 48);
    drive_edge();
    @(negedge clk);
    check("rerst_halted", 32'(halted),    32'd0);
    check("rerst_valid",  32'(dec.valid), 32'd0);
    drive_edge(); rst = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("reboot_valid", 32'(dec.valid), 32'd1);
    check("reboot_pc",    dec.pc,         32'h0);
    repeat (4) @(negedge clk);

    // Misaligned target.
    drive_edge(); redirect_valid = 1'b1; redirect_pc = 32'h102;
    sbq.delete();
`ifndef FETCH_MISALIGN_EN
    push_stream(32'h100, 48);
`endif
    drive_edge(); redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_EN
    check("mis_halted",   32'(halted),    32'd1);
    check("mis_fault",    32'(fault),     32'd1);
    check("mis_fault_pc", fault_pc,       32'h102);
    check("mis_valid",    32'(dec.valid), 32'd0);
`else
    check("mis_addr", 32'(imem_addr), 32'h40);
    @(negedge clk);
    @(negedge clk);
    check("mis_valid", 32'(dec.valid), 32'd1);
    check("mis_pc",    dec.pc,         32'h100);
`endif
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
